// File: rtl/mprj_chk_pkg.sv
// Shared types and constants for the Caravel output-bus sequence checker.
package mprj_chk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    CHECK = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } chk_state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_STRICT  = 2'd2;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mprj_stable_filter.sv
// Glitch filter: emits one event per distinct run of obs once the run has
// lasted STABLE_CYCLES samples; cleared whenever en is low.
module mprj_stable_filter #(
  parameter int WIDTH         = 28,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             en,
  input  logic [WIDTH-1:0] obs,
  output logic             stable_pulse,
  output logic             stable_level,
  output logic [WIDTH-1:0] stable_value
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] prev_q;
  logic             valid_q;
  logic [RUN_W-1:0] run_q;
  logic             fired_q;
  logic             pulse_q;
  logic [WIDTH-1:0] value_q;

  logic             new_run;
  logic [RUN_W-1:0] run_d;
  logic             pulse_d;
  logic             fired_d;

  always_comb begin
    new_run = !valid_q || (obs != prev_q);
    if (new_run)
      run_d = RUN_W'(1);
    else if (run_q == RUN_MAX)
      run_d = RUN_MAX;
    else
      run_d = run_q + RUN_W'(1);
    // fired_q keeps a saturated run from re-triggering
    pulse_d = (run_d == RUN_MAX) && (new_run || !fired_q);
    fired_d = new_run ? pulse_d : (fired_q || pulse_d);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      prev_q  <= '0;
      valid_q <= 1'b0;
      run_q   <= '0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
      value_q <= '0;
    end else if (!en) begin
      prev_q  <= '0;
      valid_q <= 1'b0;
      run_q   <= '0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
      value_q <= '0;
    end else begin
      prev_q  <= obs;
      valid_q <= 1'b1;
      run_q   <= run_d;
      fired_q <= fired_d;
      pulse_q <= pulse_d;
      if (pulse_d)
        value_q <= obs;
    end
  end

  assign stable_pulse = pulse_q;
  assign stable_level = fired_q;
  assign stable_value = value_q;

endmodule

// File: rtl/mprj_seq_checker.sv
// Checks that the user-project output bus walks through a loaded table of
// expected values, with glitch filtering, strict mode and per-step timeout.
//
// state | meaning
// IDLE  | waiting for arm; table writable
// ARMED | strict/count latched, filter running, waiting for ready
// CHECK | matching stable values against table[match_idx]
// PASS  | all entries matched; held until clear
// FAIL  | timeout or strict mismatch; held until clear
module mprj_seq_checker
  import mprj_chk_pkg::*;
#(
  parameter int WIDTH          = 28,
  parameter int DEPTH          = 16,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 32,
  localparam int IW = idx_w(DEPTH),
  localparam int CW = IW + 1
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] obs,
  input  logic             ready,
  input  logic             strict,
  input  logic             load_en,
  input  logic [IW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    num_exp,
  input  logic             arm,
  input  logic             clear,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CW-1:0]    match_idx,
  output logic [WIDTH-1:0] fail_value
);

  localparam logic [TO_W-1:0] TO_INIT = TO_W'(TIMEOUT_CYCLES);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  chk_state_t       state_q, state_d;
  logic             strict_q, strict_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    match_idx_q, match_idx_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [WIDTH-1:0] fail_value_q, fail_value_d;
  logic [WIDTH-1:0] last_match_q, last_match_d;
  logic             have_match_q, have_match_d;
  logic             first_q, first_d;

  logic [WIDTH-1:0] table_q [DEPTH];

  logic             filt_en;
  logic             stable_pulse;
  logic             stable_level;
  logic [WIDTH-1:0] stable_value;
  logic             stable_evt;
  logic [WIDTH-1:0] exp_value;
  logic [CW-1:0]    num_clamped;

  assign busy    = (state_q == ARMED) || (state_q == CHECK);
  assign filt_en = busy;

  mprj_stable_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clock        (clock),
    .resetb       (resetb),
    .en           (filt_en),
    .obs          (obs),
    .stable_pulse (stable_pulse),
    .stable_level (stable_level),
    .stable_value (stable_value)
  );

  // A value that settled while still ARMED is replayed on the first CHECK cycle
  assign stable_evt  = stable_pulse || (first_q && stable_level);
  assign exp_value   = table_q[match_idx_q[IW-1:0]];
  assign num_clamped = (num_exp > DEPTH_C) ? DEPTH_C : num_exp;

  always_ff @(posedge clock) begin
    if (load_en && !busy)
      table_q[load_addr] <= load_data;
  end

  always_comb begin
    state_d      = state_q;
    strict_d     = strict_q;
    count_d      = count_q;
    match_idx_d  = match_idx_q;
    tcnt_d       = tcnt_q;
    fail_code_d  = fail_code_q;
    fail_value_d = fail_value_q;
    last_match_d = last_match_q;
    have_match_d = have_match_q;
    first_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d      = ARMED;
          strict_d     = strict;
          count_d      = num_clamped;
          match_idx_d  = '0;
          fail_code_d  = FC_NONE;
          fail_value_d = '0;
          have_match_d = 1'b0;
        end
      end
      ARMED: begin
        if (ready) begin
          if (count_q == '0) begin
            state_d = PASS;
          end else begin
            state_d = CHECK;
            tcnt_d  = TO_INIT;
            first_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (stable_evt && (stable_value == exp_value)) begin
          match_idx_d  = match_idx_q + CW'(1);
          tcnt_d       = TO_INIT;
          last_match_d = stable_value;
          have_match_d = 1'b1;
          if ((match_idx_q + CW'(1)) == count_q)
            state_d = PASS;
        end else if (stable_evt && strict_q &&
                     !(have_match_q && (stable_value == last_match_q))) begin
          state_d      = FAIL;
          fail_code_d  = FC_STRICT;
          fail_value_d = stable_value;
        end else if (TO_EN && (tcnt_q == '0)) begin
          state_d      = FAIL;
          fail_code_d  = FC_TIMEOUT;
          fail_value_d = stable_value;
        end else if (tcnt_q != '0) begin
          tcnt_d = tcnt_q - TO_W'(1);
        end
      end
      default: ;
    endcase

    if (clear) begin
      state_d      = IDLE;
      match_idx_d  = '0;
      fail_code_d  = FC_NONE;
      fail_value_d = '0;
      have_match_d = 1'b0;
      first_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      strict_q     <= 1'b0;
      count_q      <= '0;
      match_idx_q  <= '0;
      tcnt_q       <= '0;
      fail_code_q  <= FC_NONE;
      fail_value_q <= '0;
      last_match_q <= '0;
      have_match_q <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      strict_q     <= strict_d;
      count_q      <= count_d;
      match_idx_q  <= match_idx_d;
      tcnt_q       <= tcnt_d;
      fail_code_q  <= fail_code_d;
      fail_value_q <= fail_value_d;
      last_match_q <= last_match_d;
      have_match_q <= have_match_d;
      first_q      <= first_d;
    end
  end

  assign pass       = (state_q == PASS);
  assign fail       = (state_q == FAIL);
  assign fail_code  = fail_code_q;
  assign match_idx  = match_idx_q;
  assign fail_value = fail_value_q;

endmodule

// File: tb/tb_mprj_seq_checker.sv
// Directed bench for mprj_seq_checker (TIMEOUT_CYCLES=50, STABLE_CYCLES=4).
module tb_mprj_seq_checker;

  localparam int W  = 28;
  localparam int D  = 16;
  localparam int IW = 4;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic [W-1:0]  obs = '0;
  logic          ready = 1'b0;
  logic          strict = 1'b0;
  logic          load_en = 1'b0;
  logic [IW-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic [CW-1:0] num_exp = '0;
  logic          arm = 1'b0;
  logic          clear = 1'b0;
  logic          busy;
  logic          pass;
  logic          fail;
  logic [1:0]    fail_code;
  logic [CW-1:0] match_idx;
  logic [W-1:0]  fail_value;

  int n_cmp = 0;
  int n_err = 0;

  mprj_seq_checker #(
    .WIDTH          (W),
    .DEPTH          (D),
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (50),
    .TO_W           (32)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .obs        (obs),
    .ready      (ready),
    .strict     (strict),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .num_exp    (num_exp),
    .arm        (arm),
    .clear      (clear),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code),
    .match_idx  (match_idx),
    .fail_value (fail_value)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_entry(input int a, input int d);
    load_addr = IW'(a);
    load_data = W'(d);
    load_en   = 1'b1;
    tick(1);
    load_en   = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic hold(input int v, input int n);
    obs = W'(v);
    tick(n);
  endtask

  initial begin
    tick(3);
    resetb = 1'b1;
    tick(1);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_pass", 32'(pass), 0);
    check_val("rst_fail", 32'(fail), 0);
    check_val("rst_code", 32'(fail_code), 0);
    check_val("rst_idx", 32'(match_idx), 0);
    check_val("rst_fval", 32'(fail_value), 0);

    // ordered mode, intermediate 7 ignored
    load_entry(0, 1);
    load_entry(1, 2);
    load_entry(2, 6);
    load_entry(3, 24);
    num_exp = 5'd4;
    strict  = 1'b0;
    obs     = 28'd1;
    pulse_arm();
    check_val("armed_busy", 32'(busy), 1);
    ready = 1'b1;
    hold(1, 10);
    hold(7, 10);
    hold(2, 10);
    hold(6, 10);
    hold(24, 10);
    check_val("ord_pass", 32'(pass), 1);
    check_val("ord_fail", 32'(fail), 0);
    check_val("ord_idx", 32'(match_idx), 4);
    check_val("ord_busy", 32'(busy), 0);

    // strict mode: 7 after the held 1 fails
    ready = 1'b0;
    pulse_clear();
    strict = 1'b1;
    obs    = 28'd1;
    pulse_arm();
    ready = 1'b1;
    hold(1, 10);
    hold(7, 10);
    check_val("str_fail", 32'(fail), 1);
    check_val("str_code", 32'(fail_code), 2);
    check_val("str_fval", 32'(fail_value), 7);
    check_val("str_idx", 32'(match_idx), 1);
    check_val("str_pass", 32'(pass), 0);

    // timeout: fail exactly 51 cycles after CHECK entry
    ready = 1'b0;
    pulse_clear();
    strict = 1'b0;
    load_entry(0, 5);
    num_exp = 5'd1;
    obs     = 28'd3;
    pulse_arm();
    ready = 1'b1;
    tick(1);
    tick(50);
    check_val("to_early", 32'(fail), 0);
    tick(1);
    check_val("to_fail", 32'(fail), 1);
    check_val("to_code", 32'(fail_code), 1);
    check_val("to_fval", 32'(fail_value), 3);
    check_val("to_idx", 32'(match_idx), 0);
    ready = 1'b0;
    pulse_clear();
    check_val("clr_fail", 32'(fail), 0);
    check_val("clr_code", 32'(fail_code), 0);
    check_val("clr_fval", 32'(fail_value), 0);
    check_val("clr_busy", 32'(busy), 0);

    // glitch filter: 3-sample pulse rejected, 4-sample run accepted
    obs = 28'd0;
    pulse_arm();
    ready = 1'b1;
    hold(0, 6);
    hold(5, 3);
    hold(0, 6);
    check_val("glitch_pass", 32'(pass), 0);
    check_val("glitch_idx", 32'(match_idx), 0);
    hold(5, 4);
    check_val("stab_early", 32'(pass), 0);
    tick(1);
    check_val("stab_pass", 32'(pass), 1);

    // num_exp = 0 passes straight from ARMED
    ready = 1'b0;
    pulse_clear();
    num_exp = 5'd0;
    pulse_arm();
    ready = 1'b1;
    tick(1);
    check_val("zero_pass", 32'(pass), 1);
    check_val("zero_idx", 32'(match_idx), 0);

    // num_exp above DEPTH clamps to DEPTH
    ready = 1'b0;
    pulse_clear();
    for (int i = 0; i < D; i++) load_entry(i, 100 + i);
    num_exp = 5'd19;
    obs     = 28'd100;
    pulse_arm();
    ready = 1'b1;
    for (int i = 0; i < D - 1; i++) hold(100 + i, 6);
    check_val("clamp_idx15", 32'(match_idx), 15);
    check_val("clamp_nopass", 32'(pass), 0);
    hold(100 + D - 1, 6);
    check_val("clamp_pass", 32'(pass), 1);
    check_val("clamp_idx", 32'(match_idx), 16);

    // async reset mid-CHECK
    ready = 1'b0;
    pulse_clear();
    num_exp = 5'd4;
    obs     = 28'd100;
    pulse_arm();
    ready = 1'b1;
    hold(100, 6);
    hold(101, 6);
    check_val("mid_idx", 32'(match_idx), 2);
    check_val("mid_busy", 32'(busy), 1);
    resetb = 1'b0;
    #1;
    check_val("arst_busy", 32'(busy), 0);
    check_val("arst_idx", 32'(match_idx), 0);
    check_val("arst_pass", 32'(pass), 0);
    check_val("arst_fail", 32'(fail), 0);
    tick(1);
    resetb = 1'b1;
    ready  = 1'b0;
    tick(1);
    check_val("post_rst_busy", 32'(busy), 0);

    // table writes ignored while busy
    num_exp = 5'd1;
    obs     = 28'd100;
    pulse_arm();
    load_entry(0, 77);
    hold(100, 2);
    ready = 1'b1;
    tick(8);
    check_val("wr_busy_pass", 32'(pass), 1);
    check_val("wr_busy_idx", 32'(match_idx), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mprj_seq_checker.md
Name: mprj_seq_checker

Overview:
Synthesizable, parametrised checker for the Caravel user-project output bus. It replaces hand-written chains of ordered value waits on mprj_io[35:8] with a loadable table of expected values. It adds a glitch filter, a strict/ordered mode, a per-step timeout and a pass/fail verdict with diagnostics. It sits beside the caravel instance in chip-level benches and can also be instantiated in FPGA bring-up builds.

Parameters:
WIDTH, 28, width of observed bus (mprj_io[35:8]).
DEPTH, 16, number of expected-value table entries (power of 2).
STABLE_CYCLES, 4, consecutive identical samples required before a value counts as observed (>=1).
TIMEOUT_CYCLES, 1000000, max cycles between accepted matches; 0 disables the timeout.
TO_W, 32, timeout counter width.

Ports:
clock  in  1  single clock; all state on its rising edge.
resetb  in  1  asynchronous active-low reset.
obs  in  WIDTH  observed bus value.
ready  in  1  DUT-ready indication (mprj_io[37]); checking starts only when this is high.
strict  in  1  0 = ordered mode (intermediate values ignored); 1 = strict mode (any new stable non-expected value fails). Sampled at arm.
load_en  in  1  write expected-table entry.
load_addr  in  log2(DEPTH)  table address.
load_data  in  WIDTH  expected value.
num_exp  in  log2(DEPTH)+1  count of valid entries; sampled at arm; values above DEPTH are clamped to DEPTH.
arm  in  1  one-cycle pulse: IDLE->ARMED.
clear  in  1  one-cycle pulse: any state->IDLE; verdict cleared.
busy  out  1  high in ARMED or CHECK.
pass  out  1  sticky verdict.
fail  out  1  sticky verdict.
fail_code  out  2  0 none, 1 timeout, 2 strict mismatch.
match_idx  out  log2(DEPTH)+1  number of entries matched so far.
fail_value  out  WIDTH  last stable value at failure.

Behaviour:
- Reset: state IDLE. All outputs 0. Stability filter, timeout counter and match index cleared. Table contents undefined.
- FSM: IDLE -arm-> ARMED -ready-> CHECK -> PASS | FAIL. PASS/FAIL hold until clear or reset. clear has priority over all other transitions.
- Table write: a load_en write takes effect next cycle. Writes are ignored while busy=1.
- ARMED: latches strict and clamped num_exp. If the latched count is 0, goes to PASS on the first cycle ready=1 (no CHECK state).
- Stability filter:
  - Register previous obs and a saturating run counter.
  - A value becomes "stable" on the cycle its run count reaches STABLE_CYCLES.
  - A stable event fires once per distinct run. A bus that never changes produces exactly one event.
  - The filter runs from ARMED onward, so a value already present when ready rises is counted once it has been stable for STABLE_CYCLES.
- CHECK, on a stable event:
  - Value equals table[match_idx]: increment match_idx and reload the timeout counter. If the increment reaches the count, go to PASS next cycle.
  - Value does not match, ordered mode: ignored.
  - Value does not match, strict mode: go to FAIL with code 2 and capture fail_value. The value equal to the previous match is exempt (no re-fail on the held value).
- Timeout:
  - Counter is loaded with TIMEOUT_CYCLES on entry to CHECK and on each match; decrements each CHECK cycle.
  - Reaching 0 without a match: FAIL code 1, fail_value = current filtered value.
  - A match and expiry in the same cycle: the match wins.
- Repeated expected values (e.g. 5,5): each entry needs its own stable event, so the bus must change and return between them.
- ready drops during CHECK: ignored. Checking continues.
- Latency: pass/fail assert 1 cycle after the deciding stable event or expiry.
- Reset mid-operation: returns immediately to IDLE with all outputs 0.

Decomposition:
- Shared package mprj_chk_pkg: state enum (IDLE, ARMED, CHECK, PASS, FAIL), fail_code constants (FC_NONE, FC_TIMEOUT, FC_STRICT), and a clog2-based index-width helper.
- One natural sub-module: mprj_stable_filter (obs, run counter, stable_pulse, stable_value), parametrised by WIDTH and STABLE_CYCLES.

Test Plan:
1. Load {1,2,6,24}, num_exp=4, ordered, arm, ready=1; drive 1,7,2,6,24, each held 10 cycles -> pass=1, match_idx=4, fail=0.
2. Same table, strict=1; drive 1,7 -> fail=1, fail_code=2, fail_value=7, match_idx=1.
3. TIMEOUT_CYCLES=50, table {5}; hold obs=3 -> fail_code=1 exactly 51 cycles after CHECK entry, fail_value=3.
4. STABLE_CYCLES=4, table {5}; pulse obs=5 for 3 cycles then 0 -> no match; then hold 5 for 4 cycles -> pass 1 cycle after the 4th sample.
5. num_exp=0, arm, ready=1 -> pass=1 with no CHECK state. num_exp=DEPTH+3 -> behaves as DEPTH entries.
6. Assert resetb low mid-CHECK with match_idx=2 -> all outputs 0 and state IDLE. clear after FAIL -> IDLE, fail=0. load_en while busy leaves the table unchanged.
